// File: rtl/dm_pkg.sv
// Shared constants, clear-FSM state type and the masked write-merge helper
// for the data-memory responder.
package dm_pkg;

    localparam int DM_WORD_BYTES  = 4;
    localparam int DM_DEPTH_WORDS = 16384;
    localparam int DM_ADDR_W      = 14;

    typedef enum logic {
        DM_CLEAR,
        DM_READY
    } dm_state_e;

    // Bit i of mask_n low takes data bit i; high keeps the old bit.
    function automatic logic [31:0] dm_merge(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [31:0] mask_n);
        return (old & mask_n) | (data & ~mask_n);
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// LSU <-> data-memory port bundle. The LSU drives the master side and the
// responder sits on the slave side.
interface dm_responder_if;

    logic        DM_c_en;
    logic        DM_r_en;
    logic [31:0] DM_w_en;
    logic [31:0] DM_addr;
    logic [31:0] DM_w_data;
    logic [31:0] DM_rd_data;
    logic        dm_busy;
    logic        dm_err;

    modport master (
        output DM_c_en, DM_r_en, DM_w_en, DM_addr, DM_w_data,
        input  DM_rd_data, dm_busy, dm_err
    );

    modport slave (
        input  DM_c_en, DM_r_en, DM_w_en, DM_addr, DM_w_data,
        output DM_rd_data, dm_busy, dm_err
    );

endinterface

// File: rtl/dm_sram_1rw.sv
// Behavioral single-port SRAM with per-bit active-low write mask and a
// registered read port; rdata holds until the next read.
module dm_sram_1rw
    import dm_pkg::*;
#(
    parameter int DEPTH  = DM_DEPTH_WORDS,
    parameter int ADDR_W = DM_ADDR_W
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       bmask_n,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q, rdata_d;

    // Masked word write into the array.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[idx] <= dm_merge(mem[idx], wdata, bmask_n);
        end
    end

    // Capture the addressed word on a read, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem[idx];
        end
    end

    // Read data register.
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: decodes the LSU's DM port, range-checks the byte
// address, keeps a sticky error flag and, when DM_RESPONDER_CLEAR_EN is
// defined, zero-fills the array after reset while holding dm_busy high.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
    parameter int ADDR_W      = DM_ADDR_W
) (
    input  logic           clk,
    input  logic           rst,
    dm_responder_if.slave  dm
);

    logic              busy;
    logic              clear_we;
    logic [ADDR_W-1:0] clr_idx;

`ifdef DM_RESPONDER_CLEAR_EN
    dm_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;

    // Clear FSM state and walking index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DM_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // One zero word per cycle; the last index hands over to READY for good.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clear_we  = 1'b0;
        busy      = 1'b0;
        case (state_q)
            DM_CLEAR: begin
                busy     = 1'b1;
                clear_we = 1'b1;
                if (clr_idx_q == ADDR_W'(DEPTH_WORDS - 1)) begin
                    state_d = DM_READY;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign clr_idx = clr_idx_q;
`else
    assign busy     = 1'b0;
    assign clear_we = 1'b0;
    assign clr_idx  = '0;
`endif

    logic              accept;
    logic              oor;
    logic              sram_en, sram_we;
    logic [ADDR_W-1:0] sram_idx;
    logic [31:0]       sram_mask_n, sram_wdata, sram_rdata;
    logic              rd_zero_q, rd_zero_d;
    logic              err_q, err_d;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^dm.DM_addr[1:0];

    assign accept = !dm.DM_c_en && !busy;
    assign oor    = |dm.DM_addr[31:ADDR_W+2];

    // Array port mux: the clear walker owns the port while busy.
    always_comb begin
        sram_en     = 1'b0;
        sram_we     = 1'b0;
        sram_idx    = dm.DM_addr[ADDR_W+1:2];
        sram_mask_n = dm.DM_w_en;
        sram_wdata  = dm.DM_w_data;
        if (clear_we) begin
            sram_en     = 1'b1;
            sram_we     = 1'b1;
            sram_idx    = clr_idx;
            sram_mask_n = '0;
            sram_wdata  = '0;
        end else if (accept && !oor) begin
            sram_en = 1'b1;
            sram_we = !dm.DM_r_en;
        end
    end

    // An accepted read decides whether the output shows array data or zero;
    // out-of-range accesses latch the sticky error.
    always_comb begin
        rd_zero_d = rd_zero_q;
        err_d     = err_q;
        if (accept && dm.DM_r_en) begin
            rd_zero_d = oor;
        end
        if (accept && oor) begin
            err_d = 1'b1;
        end
    end

    // Control flops; rd_zero forces the reset value of DM_rd_data to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_zero_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            rd_zero_q <= rd_zero_d;
            err_q     <= err_d;
        end
    end

    dm_sram_1rw #(
        .DEPTH  (DEPTH_WORDS),
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk     (clk),
        .en      (sram_en),
        .we      (sram_we),
        .idx     (sram_idx),
        .bmask_n (sram_mask_n),
        .wdata   (sram_wdata),
        .rdata   (sram_rdata)
    );

    assign dm.DM_rd_data = rd_zero_q ? 32'h0 : sram_rdata;
    assign dm.dm_busy    = busy;
    assign dm.dm_err     = err_q;

endmodule
